// File: rtl/pixel_pair_packer_if.sv
// Pixel input / pair output bundle for pixel_pair_packer.
// Handshake: pix_valid qualifies pix_sof, pix_r/g/b, bright_en and
// bright_offset for exactly one cycle and is always accepted (there is no
// ready). hsync qualifies DATA_WRITE_* and frame_done for exactly one cycle;
// the sink must take every pulse.
interface pixel_pair_packer_if;
    logic       pix_valid;
    logic       pix_sof;
    logic [7:0] pix_r;
    logic [7:0] pix_g;
    logic [7:0] pix_b;
    logic       bright_en;
    logic [8:0] bright_offset;

    logic       hsync;
    logic [7:0] DATA_WRITE_R0;
    logic [7:0] DATA_WRITE_G0;
    logic [7:0] DATA_WRITE_B0;
    logic [7:0] DATA_WRITE_R1;
    logic [7:0] DATA_WRITE_G1;
    logic [7:0] DATA_WRITE_B1;
    logic       frame_done;
    logic       sof_err;
    logic       fsm_state;   // packer state, 0 = IDLE, 1 = ACTIVE

    modport master (
        output pix_valid, pix_sof, pix_r, pix_g, pix_b, bright_en, bright_offset,
        input  hsync, DATA_WRITE_R0, DATA_WRITE_G0, DATA_WRITE_B0,
               DATA_WRITE_R1, DATA_WRITE_G1, DATA_WRITE_B1,
               frame_done, sof_err, fsm_state
    );

    modport slave (
        input  pix_valid, pix_sof, pix_r, pix_g, pix_b, bright_en, bright_offset,
        output hsync, DATA_WRITE_R0, DATA_WRITE_G0, DATA_WRITE_B0,
               DATA_WRITE_R1, DATA_WRITE_G1, DATA_WRITE_B1,
               frame_done, sof_err, fsm_state
    );
endinterface

// File: rtl/pixel_pair_packer.sv
// Brightness-adjusts incoming RGB pixels and packs consecutive pixels into
// left/right pairs, one hsync per pair, framed by sof and column/row counters.
module pixel_pair_packer #(
    parameter int WIDTH  = 768,
    parameter int HEIGHT = 512
) (
    input logic               HCLK,
    input logic               HRESETn,
    pixel_pair_packer_if.slave bus
);
    localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    // Saturating add of a signed 9-bit offset to an unsigned 8-bit component.
    function automatic logic [7:0] adjust(input logic [7:0] c, input logic en,
                                          input logic [8:0] off);
        logic signed [9:0] sum;
        sum = $signed({2'b00, c}) + $signed({off[8], off});
        if (!en)
            adjust = c;
        else if (sum < 0)
            adjust = 8'd0;
        else if (sum > 10'sd255)
            adjust = 8'hff;
        else
            adjust = sum[7:0];
    endfunction

    // Stage 1 registers
    logic       s1_valid;
    logic       s1_sof;
    logic [7:0] s1_r, s1_g, s1_b;

    // Stage 2 state
    state_t        state, state_next;
    logic [CW-1:0] col;          // column of the next accepted pixel
    logic [RW-1:0] row;          // row of the next accepted pixel
    logic [7:0]    hold_r, hold_g, hold_b;
    logic          hsync_q, frame_done_q, sof_err_q;
    logic [7:0]    r0_q, g0_q, b0_q, r1_q, g1_q, b1_q;

    // Control strobes from the FSM output decode
    logic restart, load_even, emit_pair, emit_done, set_err;
    logic at_last;

    assign at_last = (col == COL_LAST) && (row == ROW_LAST);

    // Stage 1: capture and brightness-adjust each valid pixel.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            s1_valid <= 1'b0;
            s1_sof   <= 1'b0;
            s1_r     <= 8'd0;
            s1_g     <= 8'd0;
            s1_b     <= 8'd0;
        end else begin
            s1_valid <= bus.pix_valid;
            if (bus.pix_valid) begin
                s1_sof <= bus.pix_sof;
                s1_r   <= adjust(bus.pix_r, bus.bright_en, bus.bright_offset);
                s1_g   <= adjust(bus.pix_g, bus.bright_en, bus.bright_offset);
                s1_b   <= adjust(bus.pix_b, bus.bright_en, bus.bright_offset);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state <= IDLE;
        else          state <= state_next;
    end

    // FSM next state: sof starts a frame, the final pair ends it.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (s1_valid && s1_sof) state_next = ACTIVE;
            ACTIVE: if (s1_valid && !s1_sof && col[0] && at_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM output decode: sof always wins, so a sof on the last pixel restarts.
    always_comb begin
        restart   = 1'b0;
        load_even = 1'b0;
        emit_pair = 1'b0;
        emit_done = 1'b0;
        set_err   = 1'b0;
        if (s1_valid) begin
            case (state)
                IDLE: restart = s1_sof;
                ACTIVE: begin
                    if (s1_sof) begin
                        restart = 1'b1;
                        set_err = (col != '0) || (row != '0);
                    end else if (!col[0]) begin
                        load_even = 1'b1;
                    end else begin
                        emit_pair = 1'b1;
                        emit_done = at_last;
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath: holding registers, counters, pair outputs and error flag.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            col          <= '0;
            row          <= '0;
            hold_r       <= 8'd0;
            hold_g       <= 8'd0;
            hold_b       <= 8'd0;
            hsync_q      <= 1'b0;
            frame_done_q <= 1'b0;
            sof_err_q    <= 1'b0;
            r0_q         <= 8'd0;
            g0_q         <= 8'd0;
            b0_q         <= 8'd0;
            r1_q         <= 8'd0;
            g1_q         <= 8'd0;
            b1_q         <= 8'd0;
        end else begin
            hsync_q      <= emit_pair;
            frame_done_q <= emit_done;
            sof_err_q    <= sof_err_q | set_err;
            if (restart || load_even) begin
                hold_r <= s1_r;
                hold_g <= s1_g;
                hold_b <= s1_b;
            end
            if (emit_pair) begin
                r0_q <= hold_r;
                g0_q <= hold_g;
                b0_q <= hold_b;
                r1_q <= s1_r;
                g1_q <= s1_g;
                b1_q <= s1_b;
            end
            if (restart) begin
                col <= CW'(1);
                row <= '0;
            end else if (load_even) begin
                col <= col + CW'(1);
            end else if (emit_pair) begin
                if (at_last) begin
                    col <= '0;
                    row <= '0;
                end else if (col == COL_LAST) begin
                    col <= '0;
                    row <= row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
        end
    end

    assign bus.hsync         = hsync_q;
    assign bus.frame_done    = frame_done_q;
    assign bus.sof_err       = sof_err_q;
    assign bus.DATA_WRITE_R0 = r0_q;
    assign bus.DATA_WRITE_G0 = g0_q;
    assign bus.DATA_WRITE_B0 = b0_q;
    assign bus.DATA_WRITE_R1 = r1_q;
    assign bus.DATA_WRITE_G1 = g1_q;
    assign bus.DATA_WRITE_B1 = b1_q;
    assign bus.fsm_state     = state;
endmodule

// File: tb/tb_pixel_pair_packer.sv
// Directed bench for pixel_pair_packer with a 4x2 frame.
module tb_pixel_pair_packer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pixel_pair_packer_if bus();

    pixel_pair_packer #(.WIDTH(4), .HEIGHT(2)) dut (
        .HCLK(clk),
        .HRESETn(rst_n),
        .bus(bus)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_cyc = 0;

    // {frame_done, R0, G0, B0, R1, G1, B1}
    logic [48:0] cap_q[$];
    int          cap_cyc[$];
    logic [48:0] exp_q[$];
    int          exp_cyc[$];

    // Cycle counter
    always @(posedge clk) cyc <= cyc + 1;

    // Record every pair output, sampled on the falling edge.
    always @(negedge clk) begin
        if (bus.hsync === 1'b1) begin
            cap_q.push_back({bus.frame_done, bus.DATA_WRITE_R0, bus.DATA_WRITE_G0,
                             bus.DATA_WRITE_B0, bus.DATA_WRITE_R1, bus.DATA_WRITE_G1,
                             bus.DATA_WRITE_B1});
            cap_cyc.push_back(cyc);
        end
    end

    function automatic logic [48:0] pk(input logic d, input logic [7:0] r0, g0, b0,
                                       input logic [7:0] r1, g1, b1);
        return {d, r0, g0, b0, r1, g1, b1};
    endfunction

    task automatic drive(input logic [7:0] r, g, b, input logic sof, input logic en,
                         input logic [8:0] off);
        @(negedge clk);
        bus.pix_valid     = 1'b1;
        bus.pix_sof       = sof;
        bus.pix_r         = r;
        bus.pix_g         = g;
        bus.pix_b         = b;
        bus.bright_en     = en;
        bus.bright_offset = off;
        last_cyc          = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.pix_valid = 1'b0;
            bus.pix_sof   = 1'b0;
        end
    endtask

    task automatic clear_q();
        cap_q.delete();
        cap_cyc.delete();
        exp_q.delete();
        exp_cyc.delete();
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++; if (bus.hsync !== 1'b0) begin bad++; $display("FAIL reset_hsync: got %0b want 0", bus.hsync); end
        total++; if (bus.frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done: got %0b want 0", bus.frame_done); end
        total++; if (bus.sof_err !== 1'b0) begin bad++; $display("FAIL reset_sof_err: got %0b want 0", bus.sof_err); end
        total++; if (bus.DATA_WRITE_R0 !== 8'd0) begin bad++; $display("FAIL reset_r0: got %0d want 0", bus.DATA_WRITE_R0); end
        total++; if (bus.DATA_WRITE_B1 !== 8'd0) begin bad++; $display("FAIL reset_b1: got %0d want 0", bus.DATA_WRITE_B1); end
        total++; if (bus.fsm_state !== 1'b0) begin bad++; $display("FAIL reset_state: got %0b want 0", bus.fsm_state); end
        rst_n = 1'b1;
    endtask

    task automatic test_continuous();
        clear_q();
        for (int i = 0; i < 8; i++) begin
            drive(8'(i), 8'(i), 8'(i), i == 0, 1'b0, 9'd0);
            if (i % 2 == 1) begin
                exp_q.push_back(pk(i == 7, 8'(i - 1), 8'(i - 1), 8'(i - 1), 8'(i), 8'(i), 8'(i)));
                exp_cyc.push_back(last_cyc + 2);
            end
        end
        idle(4);
        total++; if (cap_q.size() != exp_q.size()) begin bad++; $display("FAIL cont_count: got %0d want %0d", cap_q.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k < cap_q.size()) begin
                total++; if (cap_q[k] !== exp_q[k]) begin bad++; $display("FAIL cont_pair%0d: got %h want %h", k, cap_q[k], exp_q[k]); end
                total++; if (cap_cyc[k] != exp_cyc[k]) begin bad++; $display("FAIL cont_latency%0d: got cycle %0d want %0d", k, cap_cyc[k], exp_cyc[k]); end
            end
        end
        total++; if (bus.fsm_state !== 1'b0) begin bad++; $display("FAIL cont_idle_after: got %0b want 0", bus.fsm_state); end
        total++; if (bus.sof_err !== 1'b0) begin bad++; $display("FAIL cont_sof_err: got %0b want 0", bus.sof_err); end
    endtask

    task automatic test_saturation();
        clear_q();
        drive(8'd250, 8'd10, 8'd128, 1'b1, 1'b1, 9'h00A);
        drive(8'd250, 8'd10, 8'd128, 1'b0, 1'b1, 9'h1EC);
        exp_q.push_back(pk(1'b0, 8'd255, 8'd20, 8'd138, 8'd230, 8'd0, 8'd108));
        drive(8'd250, 8'd10, 8'd128, 1'b0, 1'b0, 9'h00A);
        drive(8'd250, 8'd10, 8'd128, 1'b0, 1'b0, 9'h1EC);
        exp_q.push_back(pk(1'b0, 8'd250, 8'd10, 8'd128, 8'd250, 8'd10, 8'd128));
        drive(8'd0, 8'd255, 8'd1, 1'b0, 1'b1, 9'h100);
        drive(8'd0, 8'd255, 8'd1, 1'b0, 1'b1, 9'h0FF);
        exp_q.push_back(pk(1'b0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd255, 8'd255));
        drive(8'd7, 8'd8, 8'd9, 1'b0, 1'b0, 9'h100);
        drive(8'd10, 8'd11, 8'd12, 1'b0, 1'b0, 9'h0FF);
        exp_q.push_back(pk(1'b1, 8'd7, 8'd8, 8'd9, 8'd10, 8'd11, 8'd12));
        idle(4);
        total++; if (cap_q.size() != exp_q.size()) begin bad++; $display("FAIL sat_count: got %0d want %0d", cap_q.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k < cap_q.size()) begin
                total++; if (cap_q[k] !== exp_q[k]) begin bad++; $display("FAIL sat_pair%0d: got %h want %h", k, cap_q[k], exp_q[k]); end
            end
        end
        total++; if (bus.sof_err !== 1'b0) begin bad++; $display("FAIL sat_sof_after_frame: got %0b want 0", bus.sof_err); end
    endtask

    task automatic test_gapped();
        clear_q();
        for (int i = 0; i < 8; i++) begin
            drive(8'(i), 8'(i), 8'(i), i == 0, 1'b0, 9'd0);
            if (i % 2 == 1) begin
                exp_q.push_back(pk(i == 7, 8'(i - 1), 8'(i - 1), 8'(i - 1), 8'(i), 8'(i), 8'(i)));
                exp_cyc.push_back(last_cyc + 2);
            end
            idle(1);
        end
        idle(4);
        total++; if (cap_q.size() != exp_q.size()) begin bad++; $display("FAIL gap_count: got %0d want %0d", cap_q.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k < cap_q.size()) begin
                total++; if (cap_q[k] !== exp_q[k]) begin bad++; $display("FAIL gap_pair%0d: got %h want %h", k, cap_q[k], exp_q[k]); end
                total++; if (cap_cyc[k] != exp_cyc[k]) begin bad++; $display("FAIL gap_latency%0d: got cycle %0d want %0d", k, cap_cyc[k], exp_cyc[k]); end
                if (k > 0) begin
                    total++; if (cap_cyc[k] - cap_cyc[k - 1] != 4) begin bad++; $display("FAIL gap_spacing%0d: got %0d want 4", k, cap_cyc[k] - cap_cyc[k - 1]); end
                end
            end
        end
    endtask

    task automatic test_restart();
        clear_q();
        drive(8'd100, 8'd100, 8'd100, 1'b1, 1'b0, 9'd0);
        drive(8'd101, 8'd101, 8'd101, 1'b0, 1'b0, 9'd0);
        drive(8'd102, 8'd102, 8'd102, 1'b0, 1'b0, 9'd0);
        exp_q.push_back(pk(1'b0, 8'd100, 8'd100, 8'd100, 8'd101, 8'd101, 8'd101));
        idle(2);
        total++; if (bus.sof_err !== 1'b0) begin bad++; $display("FAIL rst_err_early: got %0b want 0", bus.sof_err); end
        for (int i = 0; i < 8; i++) begin
            drive(8'(50 + i), 8'(50 + i), 8'(50 + i), i == 0, 1'b0, 9'd0);
            if (i == 0) begin
                idle(2);
                total++; if (bus.sof_err !== 1'b1) begin bad++; $display("FAIL rst_err_set: got %0b want 1", bus.sof_err); end
            end
            if (i % 2 == 1)
                exp_q.push_back(pk(i == 7, 8'(49 + i), 8'(49 + i), 8'(49 + i), 8'(50 + i), 8'(50 + i), 8'(50 + i)));
        end
        idle(4);
        total++; if (cap_q.size() != exp_q.size()) begin bad++; $display("FAIL rst_count: got %0d want %0d", cap_q.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k < cap_q.size()) begin
                total++; if (cap_q[k] !== exp_q[k]) begin bad++; $display("FAIL rst_pair%0d: got %h want %h", k, cap_q[k], exp_q[k]); end
            end
        end
        total++; if (bus.sof_err !== 1'b1) begin bad++; $display("FAIL rst_err_sticky: got %0b want 1", bus.sof_err); end
    endtask

    task automatic test_idle_drop_reset();
        // Asynchronous reset between clock edges clears sticky error and data.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++; if (bus.sof_err !== 1'b0) begin bad++; $display("FAIL ar_sof_err: got %0b want 0", bus.sof_err); end
        total++; if (bus.DATA_WRITE_R1 !== 8'd0) begin bad++; $display("FAIL ar_r1: got %0d want 0", bus.DATA_WRITE_R1); end
        @(negedge clk);
        rst_n = 1'b1;

        clear_q();
        for (int i = 0; i < 3; i++) drive(8'(200 + i), 8'd1, 8'd2, 1'b0, 1'b0, 9'd0);
        idle(3);
        total++; if (cap_q.size() != 0) begin bad++; $display("FAIL idle_drop: got %0d pulses want 0", cap_q.size()); end
        total++; if (bus.fsm_state !== 1'b0) begin bad++; $display("FAIL idle_state: got %0b want 0", bus.fsm_state); end

        drive(8'd20, 8'd21, 8'd22, 1'b1, 1'b0, 9'd0);
        drive(8'd23, 8'd24, 8'd25, 1'b0, 1'b0, 9'd0);
        idle(3);
        total++; if (cap_q.size() != 1) begin bad++; $display("FAIL idle_sof_count: got %0d want 1", cap_q.size()); end
        else begin
            total++; if (cap_q[0] !== pk(1'b0, 8'd20, 8'd21, 8'd22, 8'd23, 8'd24, 8'd25)) begin bad++; $display("FAIL idle_sof_pair: got %h", cap_q[0]); end
        end

        // Mid-frame reset while hsync is high.
        clear_q();
        drive(8'd30, 8'd30, 8'd30, 1'b1, 1'b0, 9'd0);
        drive(8'd31, 8'd31, 8'd31, 1'b0, 1'b0, 9'd0);
        idle(1);
        @(posedge clk);
        #2;
        total++; if (bus.hsync !== 1'b1) begin bad++; $display("FAIL mid_hsync_pre: got %0b want 1", bus.hsync); end
        rst_n = 1'b0;
        #1;
        total++; if (bus.hsync !== 1'b0) begin bad++; $display("FAIL mid_hsync: got %0b want 0", bus.hsync); end
        total++; if (bus.DATA_WRITE_R0 !== 8'd0) begin bad++; $display("FAIL mid_r0: got %0d want 0", bus.DATA_WRITE_R0); end
        total++; if (bus.DATA_WRITE_G1 !== 8'd0) begin bad++; $display("FAIL mid_g1: got %0d want 0", bus.DATA_WRITE_G1); end
        total++; if (bus.fsm_state !== 1'b0) begin bad++; $display("FAIL mid_state: got %0b want 0", bus.fsm_state); end
        @(negedge clk);
        rst_n = 1'b1;

        clear_q();
        for (int i = 0; i < 4; i++) drive(8'(40 + i), 8'(40 + i), 8'(40 + i), 1'b0, 1'b0, 9'd0);
        idle(3);
        total++; if (cap_q.size() != 0) begin bad++; $display("FAIL post_reset_drop: got %0d pulses want 0", cap_q.size()); end
        drive(8'd60, 8'd60, 8'd60, 1'b1, 1'b0, 9'd0);
        drive(8'd61, 8'd61, 8'd61, 1'b0, 1'b0, 9'd0);
        idle(3);
        total++; if (cap_q.size() != 1) begin bad++; $display("FAIL post_reset_count: got %0d want 1", cap_q.size()); end
        else begin
            total++; if (cap_q[0] !== pk(1'b0, 8'd60, 8'd60, 8'd60, 8'd61, 8'd61, 8'd61)) begin bad++; $display("FAIL post_reset_pair: got %h", cap_q[0]); end
        end
    endtask

    task automatic test_sof_on_last();
        pulse_reset();
        clear_q();
        for (int i = 0; i < 7; i++) begin
            drive(8'(i), 8'(i), 8'(i), i == 0, 1'b0, 9'd0);
            if (i % 2 == 1)
                exp_q.push_back(pk(1'b0, 8'(i - 1), 8'(i - 1), 8'(i - 1), 8'(i), 8'(i), 8'(i)));
        end
        for (int i = 0; i < 8; i++) begin
            drive(8'(70 + i), 8'(70 + i), 8'(70 + i), i == 0, 1'b0, 9'd0);
            if (i == 0) begin
                idle(3);
                total++; if (bus.sof_err !== 1'b1) begin bad++; $display("FAIL last_sof_err: got %0b want 1", bus.sof_err); end
                total++; if (bus.fsm_state !== 1'b1) begin bad++; $display("FAIL last_sof_state: got %0b want 1", bus.fsm_state); end
                total++; if (cap_q.size() != 3) begin bad++; $display("FAIL last_sof_count: got %0d want 3", cap_q.size()); end
            end
            if (i % 2 == 1)
                exp_q.push_back(pk(i == 7, 8'(69 + i), 8'(69 + i), 8'(69 + i), 8'(70 + i), 8'(70 + i), 8'(70 + i)));
        end
        idle(4);
        total++; if (cap_q.size() != exp_q.size()) begin bad++; $display("FAIL last_total_count: got %0d want %0d", cap_q.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k < cap_q.size()) begin
                total++; if (cap_q[k] !== exp_q[k]) begin bad++; $display("FAIL last_pair%0d: got %h want %h", k, cap_q[k], exp_q[k]); end
            end
        end
    endtask

    initial begin
        bus.pix_valid     = 1'b0;
        bus.pix_sof       = 1'b0;
        bus.pix_r         = 8'd0;
        bus.pix_g         = 8'd0;
        bus.pix_b         = 8'd0;
        bus.bright_en     = 1'b0;
        bus.bright_offset = 9'd0;
        test_reset();
        test_continuous();
        test_saturation();
        test_gapped();
        test_restart();
        test_idle_drop_reset();
        test_sof_on_last();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
